// File: rtl/command_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : command_issuer
//  Purpose  : Turns single host register-access requests into 204-bit
//             write/read commands for the switch command parser and collects
//             the read acknowledgement. Reads are issued twice (prime, then
//             fetch) to cover the registered RAM read latency behind the
//             parser.
//  Revision : 1.0  initial release
// ============================================================================
module command_issuer #(
  parameter int RD_GAP_CYCLES  = 2,   // idle cycles between prime and fetch, 1..255
  parameter int TIMEOUT_CYCLES = 64   // cycles to wait for the read ack, 1..65535
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic         i_req_rw,
  input  logic [7:0]   iv_req_target,
  input  logic [31:0]  iv_req_addr,
  input  logic [31:0]  iv_req_wdata,
  output logic         o_rsp_valid,
  output logic [31:0]  ov_rsp_rdata,
  output logic         o_rsp_timeout,
  output logic [203:0] ov_wr_command,
  output logic         o_wr_command_wr,
  output logic [203:0] ov_rd_command,
  output logic         o_rd_command_wr,
  input  logic [203:0] iv_rd_command_ack
);

  localparam logic [3:0]  C_TYPE_WR   = 4'h1;
  localparam logic [3:0]  C_TYPE_RD   = 4'h2;
  localparam logic [3:0]  C_TYPE_ACK  = 4'h6;
  localparam logic [7:0]  C_GAP_LAST  = 8'(RD_GAP_CYCLES - 1);
  localparam logic [15:0] C_TO_LIMIT  = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_RD_PRIME = 3'd2,
    ST_RD_GAP   = 3'd3,
    ST_RD_FETCH = 3'd4,
    ST_RD_WAIT  = 3'd5,
    ST_RSP      = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_target;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [7:0]    r_gap_cnt;
  logic [7:0]    w_gap_nxt;
  logic [15:0]   r_to_cnt;
  logic [15:0]   w_to_nxt;
  logic [31:0]   w_rdata_nxt;
  logic          w_timeout_nxt;
  logic          w_accept;
  logic          w_ack_valid;
  logic          w_rd_issue;
  logic [7:0]    w_target;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [203:0]  w_wr_cmd;
  logic [203:0]  w_rd_cmd;
  logic          w_unused_ack;

  assign o_req_ready = (r_state == ST_IDLE);
  assign w_accept    = i_req_valid && (r_state == ST_IDLE);
  assign w_ack_valid = (iv_rd_command_ack[187:184] == C_TYPE_ACK);

  // Commands are registered on the transition into their issue state, so the
  // first command must be built from the live request rather than the latch.
  assign w_target = w_accept ? iv_req_target : r_target;
  assign w_addr   = w_accept ? iv_req_addr   : r_addr;
  assign w_wdata  = w_accept ? iv_req_wdata  : r_wdata;

  assign w_wr_cmd = {8'h00, w_target, C_TYPE_WR, w_addr, 120'h0, w_wdata};
  assign w_rd_cmd = {8'h00, w_target, C_TYPE_RD, w_addr, 120'h0, 32'h0};

  assign w_rd_issue = (w_state_nxt == ST_RD_PRIME) || (w_state_nxt == ST_RD_FETCH);

  // Only the type nibble and the data word of the ack carry meaning here.
  assign w_unused_ack = ^{iv_rd_command_ack[203:188], iv_rd_command_ack[183:32]};

  // Next-state, counter and response-value decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_gap_nxt     = r_gap_cnt;
    w_to_nxt      = r_to_cnt;
    w_rdata_nxt   = 32'h0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_state_nxt = i_req_rw ? ST_RD_PRIME : ST_WR_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        w_state_nxt = ST_RSP;
      end
      ST_RD_PRIME: begin
        w_state_nxt = ST_RD_GAP;
        w_gap_nxt   = 8'h0;
      end
      ST_RD_GAP: begin
        // Acks arriving here answer the prime read and are deliberately ignored.
        if (r_gap_cnt == C_GAP_LAST) begin
          w_state_nxt = ST_RD_FETCH;
        end else begin
          w_gap_nxt = r_gap_cnt + 8'h1;
        end
      end
      ST_RD_FETCH: begin
        w_state_nxt = ST_RD_WAIT;
        w_to_nxt    = 16'h0;
      end
      ST_RD_WAIT: begin
        // A valid ack wins even in the cycle the timeout would expire.
        if (w_ack_valid) begin
          w_state_nxt = ST_RSP;
          w_rdata_nxt = iv_rd_command_ack[31:0];
        end else if ((r_to_cnt + 16'h1) == C_TO_LIMIT) begin
          w_state_nxt   = ST_RSP;
          w_timeout_nxt = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + 16'h1;
        end
      end
      ST_RSP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and request latch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= 8'h0;
      r_to_cnt  <= 16'h0;
      r_target  <= 8'h0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_to_cnt  <= w_to_nxt;
      if (w_accept) begin
        r_target <= iv_req_target;
        r_addr   <= iv_req_addr;
        r_wdata  <= iv_req_wdata;
      end
    end
  end

  // Registered outputs, decoded from the next state so strobes line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_command_wr <= 1'b0;
      ov_wr_command   <= 204'h0;
      o_rd_command_wr <= 1'b0;
      ov_rd_command   <= 204'h0;
      o_rsp_valid     <= 1'b0;
      ov_rsp_rdata    <= 32'h0;
      o_rsp_timeout   <= 1'b0;
    end else begin
      o_wr_command_wr <= (w_state_nxt == ST_WR_ISSUE);
      ov_wr_command   <= (w_state_nxt == ST_WR_ISSUE) ? w_wr_cmd : 204'h0;
      o_rd_command_wr <= w_rd_issue;
      ov_rd_command   <= w_rd_issue ? w_rd_cmd : 204'h0;
      o_rsp_valid     <= (w_state_nxt == ST_RSP);
      ov_rsp_rdata    <= w_rdata_nxt;
      o_rsp_timeout   <= w_timeout_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_command_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_command_issuer
//  Purpose  : Self-checking bench for command_issuer; expected cycle timing
//             and data are derived from request/ack times with arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_command_issuer;

  localparam int G  = 2;
  localparam int TO = 4;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_req_valid = 1'b0;
  logic         o_req_ready;
  logic         i_req_rw = 1'b0;
  logic [7:0]   iv_req_target = 8'h0;
  logic [31:0]  iv_req_addr = 32'h0;
  logic [31:0]  iv_req_wdata = 32'h0;
  logic         o_rsp_valid;
  logic [31:0]  ov_rsp_rdata;
  logic         o_rsp_timeout;
  logic [203:0] ov_wr_command;
  logic         o_wr_command_wr;
  logic [203:0] ov_rd_command;
  logic         o_rd_command_wr;
  logic [203:0] iv_rd_command_ack = 204'h0;

  int checks = 0;
  int failures = 0;

  // Fields presented while a transaction is in flight (the host's next request).
  logic        n_rw;
  logic [7:0]  n_tgt;
  logic [31:0] n_addr;
  logic [31:0] n_wdata;

  command_issuer #(.RD_GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_req_valid       (i_req_valid),
    .o_req_ready       (o_req_ready),
    .i_req_rw          (i_req_rw),
    .iv_req_target     (iv_req_target),
    .iv_req_addr       (iv_req_addr),
    .iv_req_wdata      (iv_req_wdata),
    .o_rsp_valid       (o_rsp_valid),
    .ov_rsp_rdata      (ov_rsp_rdata),
    .o_rsp_timeout     (o_rsp_timeout),
    .ov_wr_command     (ov_wr_command),
    .o_wr_command_wr   (o_wr_command_wr),
    .ov_rd_command     (ov_rd_command),
    .o_rd_command_wr   (o_rd_command_wr),
    .iv_rd_command_ack (iv_rd_command_ack)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [203:0] got, input logic [203:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  function automatic logic [203:0] mk_ack(input logic [7:0] src, input logic [31:0] d);
    logic [203:0] a;
    a = 204'h0;
    a[195:188] = src;
    a[187:184] = 4'h6;
    a[31:0]    = d;
    return a;
  endfunction

  // Random bus content that is never a valid ack (type nibble differs from 6).
  function automatic logic [203:0] junk_ack();
    logic [203:0] a;
    logic [3:0]   t;
    for (int k = 0; k < 7; k++) a[k*32 +: 32] = 32'($urandom);
    t = 4'($urandom_range(0, 14));
    if (t >= 4'h6) t = t + 4'h1;
    a[187:184] = t;
    return a;
  endfunction

  function automatic logic [203:0] mk_cmd(input logic [7:0] tgt, input logic [3:0] typ,
                                          input logic [31:0] addr, input logic [31:0] data);
    logic [203:0] c;
    c = 204'h0;
    c[195:188] = tgt;
    c[187:184] = typ;
    c[183:152] = addr;
    c[31:0]    = data;
    return c;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"},  {203'h0, o_req_ready},     204'h1);
    chk({tag, "_wrstb"},  {203'h0, o_wr_command_wr}, 204'h0);
    chk({tag, "_wrcmd"},  ov_wr_command,             204'h0);
    chk({tag, "_rdstb"},  {203'h0, o_rd_command_wr}, 204'h0);
    chk({tag, "_rdcmd"},  ov_rd_command,             204'h0);
    chk({tag, "_rspv"},   {203'h0, o_rsp_valid},     204'h0);
  endtask

  task automatic idle_cycle(input string tag);
    chk_idle(tag);
    i_req_valid       = 1'b0;
    iv_rd_command_ack = junk_ack();
    step();
  endtask

  // One request accepted in relative cycle 0. ign_off: an ack placed in the
  // gap (must be ignored); ack_off: the candidate answer (-1 = none).
  task automatic do_txn(input string tag, input logic rw, input logic [7:0] tgt,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic hold,
                        input int ign_off, input logic [31:0] ign_data,
                        input int ack_off, input logic [31:0] ack_data);
    int          rsp_rel;
    int          lo;
    logic [31:0] e_data;
    logic        e_to;
    logic [203:0] e_cmd;
    e_data = 32'h0;
    e_to   = 1'b0;
    if (!rw) begin
      rsp_rel = 2;
    end else begin
      lo = 3 + G;
      if (ack_off >= lo && ack_off <= lo + TO - 1) begin
        rsp_rel = ack_off + 1;
        e_data  = ack_data;
      end else begin
        rsp_rel = lo + TO;
        e_to    = 1'b1;
      end
    end
    e_cmd = rw ? mk_cmd(tgt, 4'h2, addr, 32'h0) : mk_cmd(tgt, 4'h1, addr, wdata);
    for (int c = 0; c <= rsp_rel; c++) begin
      logic e_wr, e_rd, e_rsp;
      e_wr  = !rw && (c == 1);
      e_rd  = rw && ((c == 1) || (c == 2 + G));
      e_rsp = (c == rsp_rel);
      chk({tag, "_ready"}, {203'h0, o_req_ready},     {203'h0, (c == 0)});
      chk({tag, "_wrstb"}, {203'h0, o_wr_command_wr}, {203'h0, e_wr});
      chk({tag, "_wrcmd"}, ov_wr_command,             e_wr ? e_cmd : 204'h0);
      chk({tag, "_rdstb"}, {203'h0, o_rd_command_wr}, {203'h0, e_rd});
      chk({tag, "_rdcmd"}, ov_rd_command,             e_rd ? e_cmd : 204'h0);
      chk({tag, "_rspv"},  {203'h0, o_rsp_valid},     {203'h0, e_rsp});
      if (e_rsp) begin
        chk({tag, "_rdata"},   {172'h0, ov_rsp_rdata},  {172'h0, e_data});
        chk({tag, "_timeout"}, {203'h0, o_rsp_timeout}, {203'h0, e_to});
      end
      if (c == 0) begin
        i_req_valid = 1'b1; i_req_rw = rw; iv_req_target = tgt;
        iv_req_addr = addr; iv_req_wdata = wdata;
      end else begin
        i_req_valid = hold; i_req_rw = n_rw; iv_req_target = n_tgt;
        iv_req_addr = n_addr; iv_req_wdata = n_wdata;
      end
      if (rw && c == ign_off)      iv_rd_command_ack = mk_ack(tgt, ign_data);
      else if (rw && c == ack_off) iv_rd_command_ack = mk_ack(tgt, ack_data);
      else                         iv_rd_command_ack = junk_ack();
      step();
    end
  endtask

  // Start a request, then pull reset asynchronously at relative cycle at_rel.
  task automatic reset_mid(input string tag, input logic rw, input int at_rel);
    for (int c = 0; c < at_rel; c++) begin
      i_req_valid = (c == 0); i_req_rw = rw; iv_req_target = 8'h0c;
      iv_req_addr = 32'h40; iv_req_wdata = 32'h1234;
      iv_rd_command_ack = junk_ack();
      step();
    end
    i_req_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk_idle({tag, "_inrst"});
    chk({tag, "_rdata"},   {172'h0, ov_rsp_rdata},  204'h0);
    chk({tag, "_timeout"}, {203'h0, o_rsp_timeout}, 204'h0);
    step();
    step();
    i_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) idle_cycle({tag, "_after"});
  endtask

  initial begin
    logic        rw, hold;
    logic [7:0]  tgt;
    logic [31:0] addr, wdata, ign_d, ack_d;
    int          ign_off, ack_off;

    n_rw = 1'b0; n_tgt = 8'h0; n_addr = 32'h0; n_wdata = 32'h0;
    @(negedge i_clk);
    step();
    chk_idle("rst");
    chk("rst_rdata",   {172'h0, ov_rsp_rdata},  204'h0);
    chk("rst_timeout", {203'h0, o_rsp_timeout}, 204'h0);
    i_rst_n = 1'b1;
    idle_cycle("idle0");

    // Directed write and read cases.
    do_txn("wr",      1'b0, 8'h04, 32'h3A5, 32'h5A, 1'b0, -1, 32'h0,  -1, 32'h0);
    idle_cycle("idle1");
    do_txn("rd_ok",   1'b1, 8'h0c, 32'h10,  32'h0,  1'b0, -1, 32'h0,   5, 32'h1AB);
    do_txn("rd_ign",  1'b1, 8'h0c, 32'h10,  32'h0,  1'b0,  2, 32'hFF,  5, 32'h11);
    do_txn("rd_to",   1'b1, 8'h07, 32'h20,  32'h0,  1'b0, -1, 32'h0,  -1, 32'h0);
    do_txn("rd_exp",  1'b1, 8'h03, 32'h24,  32'h0,  1'b0, -1, 32'h0,  3 + G + TO - 1, 32'hCAFE0001);
    idle_cycle("idle2");

    // Three requests queued with valid held high throughout.
    n_rw = 1'b1; n_tgt = 8'h05; n_addr = 32'h88; n_wdata = 32'h0;
    do_txn("b2b_0", 1'b0, 8'h00, 32'h4,  32'hDEADBEEF, 1'b1, -1, 32'h0, -1, 32'h0);
    n_rw = 1'b0; n_tgt = 8'h06; n_addr = 32'h99; n_wdata = 32'h77;
    do_txn("b2b_1", 1'b1, 8'h05, 32'h88, 32'h0,        1'b1, -1, 32'h0,  6, 32'h55AA);
    do_txn("b2b_2", 1'b0, 8'h06, 32'h99, 32'h77,       1'b0, -1, 32'h0, -1, 32'h0);
    idle_cycle("idle3");

    // Reset during RD_GAP, and during a live write strobe.
    reset_mid("rst_gap", 1'b1, 3);
    reset_mid("rst_wr",  1'b0, 1);

    // Randomized requests, some held back-to-back.
    n_rw = 1'($urandom); n_tgt = 8'($urandom); n_addr = $urandom; n_wdata = $urandom;
    for (int i = 0; i < 40; i++) begin
      rw = n_rw; tgt = n_tgt; addr = n_addr; wdata = n_wdata;
      n_rw = 1'($urandom); n_tgt = 8'($urandom); n_addr = $urandom; n_wdata = $urandom;
      hold  = 1'($urandom);
      ign_off = ($urandom_range(0, 1) == 1) ? 2 + $urandom_range(0, G - 1) : -1;
      ack_off = ($urandom_range(0, 3) == 0) ? -1 : 3 + G + $urandom_range(0, TO - 1);
      ign_d = $urandom;
      ack_d = $urandom;
      do_txn("rand", rw, tgt, addr, wdata, hold, ign_off, ign_d, ack_off, ack_d);
      if (!hold) idle_cycle("rand_idle");
    end
    idle_cycle("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/command_issuer.md
Name: command_issuer

Overview:
- Initiator-side counterpart of the switch command parser: turns single host register-access requests into 204-bit write/read commands and collects read acknowledgements.
- Sits between the host/config-frame decoder and the parser. Drives the write-command, read-command and strobe ports, and consumes the 204-bit read-ack bus.
- One outstanding request at a time. Reads are issued twice (prime + fetch) to cover the registered RAM read latency behind the parser.

Parameters:
- RD_GAP_CYCLES, default 2: idle cycles between the prime read command and the fetch read command. Legal range 1..255.
- TIMEOUT_CYCLES, default 64: cycles to wait for the read ack after the fetch command. Legal range 1..65535.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  host request valid
- o_req_ready  out  1  block idle; request accepted when valid & ready
- i_req_rw  in  1  0 = write, 1 = read
- iv_req_target  in  8  target module id (0 regs, 3..7 port 0..4 qgc, 0xc flt)
- iv_req_addr  in  32  register/RAM address
- iv_req_wdata  in  32  write data
- o_rsp_valid  out  1  one-cycle completion pulse
- ov_rsp_rdata  out  32  read data; 0 for writes and timeouts
- o_rsp_timeout  out  1  qualifies o_rsp_valid; read ack not received
- ov_wr_command  out  204  write command
- o_wr_command_wr  out  1  write command strobe
- ov_rd_command  out  204  read command
- o_rd_command_wr  out  1  read command strobe
- iv_rd_command_ack  in  204  read ack from the parser

Behaviour:
- Command format:
  - [203:196] = 0
  - [195:188] = target
  - [187:184] = type (4'h1 write, 4'h2 read)
  - [183:152] = addr
  - [151:32] = 0
  - [31:0] = wdata for writes, 0 for reads
- Ack is recognised only when iv_rd_command_ack[187:184] == 4'h6. rdata is ack[31:0]; any upper bits the parser leaves zero stay zero.
- All outputs are registered except o_req_ready, which is (state == IDLE).
- Reset values: all outputs 0, except o_req_ready = 1 (state IDLE). Timeout and gap counters clear to 0.
- Command buses read 0 in every cycle their strobe is low.
- Each strobe is high for exactly one cycle per issue.
- FSM states: IDLE, WR_ISSUE, RD_PRIME, RD_GAP, RD_FETCH, RD_WAIT, RSP.
  - IDLE: on valid & ready, latch rw/target/addr/wdata. Go to WR_ISSUE if rw = 0, else RD_PRIME.
  - WR_ISSUE: o_wr_command_wr = 1 with the write command. Go to RSP with rdata = 0, timeout = 0.
  - RD_PRIME: o_rd_command_wr = 1 with the read command. Go to RD_GAP and load the gap counter.
  - RD_GAP: stay RD_GAP_CYCLES cycles. Any ack seen here is ignored. Then go to RD_FETCH.
  - RD_FETCH: o_rd_command_wr = 1 with an identical command. Go to RD_WAIT and clear the timeout counter.
  - RD_WAIT:
    - Valid ack seen: capture ack[31:0] and go to RSP with timeout = 0.
    - Counter reaches TIMEOUT_CYCLES with no ack: go to RSP with rdata = 0, timeout = 1.
    - Ack in the same cycle the counter expires: the ack wins.
  - RSP: o_rsp_valid = 1 for one cycle. Go to IDLE.
- Latency with request accepted in cycle T:
  - Write: strobe at T+1, rsp at T+2, ready at T+3.
  - Read (gap G): prime at T+1, fetch at T+2+G, ack expected at T+3+G, rsp at T+4+G.
- Requests presented while not ready are neither latched nor dropped; the host holds them.
- Unknown target or unsupported reg address is still issued. The parser returns no type-6 ack, so the read ends in timeout.
- Response has no backpressure; the host must sample o_rsp_valid.
- Reset asserted mid-operation: immediate return to IDLE, strobes and rsp forced 0. No partial command is emitted after release.

Test Plan:
- Write: rw=0, target 0x04, addr 0x000003A5, wdata 0x5A. Expect one-cycle o_wr_command_wr at T+1 with ov_wr_command = {8'h0, 8'h04, 4'h1, 32'h3A5, 120'h0, 32'h5A}, o_rsp_valid at T+2 with rdata 0, ready back at T+3.
- Read OK (G=2): rw=1, target 0x0c, addr 0x10. Expect read strobes at T+1 and T+4. Model returns ack {8'h0, 8'h3, 4'h6, 32'h0, 143'h0, 9'h1AB} at T+5. Expect o_rsp_valid at T+6 with rdata 0x000001AB, timeout 0.
- Ignored prime ack: model acks 0xFF at T+2 and 0x11 at T+5. Expect rdata 0x11.
- Timeout (TIMEOUT_CYCLES=4): read with no ack returned. Expect o_rsp_valid with timeout 1 and rdata 0, exactly 4 cycles after entering RD_WAIT.
- Ack on the expiry cycle: ack arrives in the cycle the counter reaches TIMEOUT_CYCLES. Expect timeout 0 and the captured data.
- Back-to-back and reset: hold i_req_valid high with 3 queued requests. Each is accepted only when ready, and strobes never overlap. Then assert i_rst_n low during RD_GAP. Expect all outputs 0, ready 1, and no fetch strobe after release.
